riscv_divider: RTL

Iterative restoring divider for the M-extension DIV, DIVU, REM and REMU instructions. It is the subtract-direction counterpart of the ripple-carry adder datapath, producing one quotient bit per cycle. It sits beside the EX stage. The pipeline stalls on `busy` and captures `result` on the one-cycle `done` pulse. Divide-by-zero and signed overflow resolve on a one-cycle fast path.

---
 rtl/div_pkg.sv | 30 +++
 rtl/div_step.sv | 34 +++
 rtl/riscv_divider.sv | 136 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the M-extension iterative divider.
//   DIV_W        default operand/result width
//   OP_*         funct encodings for DIV, DIVU, REM, REMU as seen on `op`
//   div_state_e  divider FSM state (IDLE, CALC, DONE), also exported for debug
//   op_signed()  1 for DIV/REM (two's-complement operands)
//   op_rem()     1 for REM/REMU (remainder selected as result)
package div_pkg;

  localparam int DIV_W = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic op_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rem(input logic [1:0] op);
    return !((op == OP_DIV) || (op == OP_DIVU));
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, purely combinational.
//   rem      current partial remainder (always < divisor)
//   divisor  divisor magnitude
//   bit_in   next dividend bit shifted into the remainder
//   rem_next partial remainder after the trial subtract/restore
//   q_bit    quotient bit produced by this iteration
// The trial subtract is an adder fed with the inverted divisor and a carry-in
// of 1; the carry out of the N+1-bit sum is the "no borrow" flag, i.e. the
// trial result is non-negative.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] divisor,
  input  logic         bit_in,
  output logic [N-1:0] rem_next,
  output logic         q_bit
);

  logic [N:0]   shifted;
  logic [N+1:0] sum;
  logic         unused_bits;

  assign shifted = {rem, bit_in};
  assign sum     = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + (N+2)'(1);
  assign q_bit   = sum[N+1];

  // Because rem < divisor on entry, both the accepted difference and the
  // restored shifted value fit back into N bits.
  assign rem_next = q_bit ? sum[N-1:0] : shifted[N-1:0];

  assign unused_bits = ^{sum[N], shifted[N]};

endmodule

// File: rtl/riscv_divider.sv
// riscv_divider: iterative restoring divider for DIV/DIVU/REM/REMU.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request; sampled with op/dividend/divisor in IDLE or DONE
//   op          00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend    rs1
//   divisor     rs2
//   kill        pipeline flush; aborts any operation, drops a same-cycle start
//   busy        high while iterating (CALC)
//   done        one-cycle pulse (DONE); result valid in this cycle
//   result      quotient or remainder; held until the next completion
//   dbg_state   current FSM state (div_state_e encoding)
// Handshake: a request is taken on any rising edge where start=1, kill=0 and
// the FSM is in IDLE or DONE; no ready signal exists, so the requester must
// hold off while busy (a start seen during CALC is silently ignored). The
// answer is reported by a single-cycle done; there is no back-pressure.
module riscv_divider
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         kill,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(N);

  div_state_e  state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem, quo, dvsr;
  logic          q_neg, r_neg, rem_sel;

  // Operand preparation for the incoming request.
  logic          sgn, a_neg, b_neg, div_zero, ovf, fast;
  logic [N-1:0]  a_mag, b_mag, fast_val;

  assign sgn      = op_signed(op);
  assign a_neg    = sgn & dividend[N-1];
  assign b_neg    = sgn & divisor[N-1];
  assign a_mag    = a_neg ? (~dividend + N'(1)) : dividend;
  assign b_mag    = b_neg ? (~divisor + N'(1)) : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = sgn && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
  assign fast     = div_zero | ovf;

  // Architectural results for the two cases that bypass iteration.
  always_comb begin
    fast_val = '0;
    if (div_zero) fast_val = op_rem(op) ? dividend : '1;
    else          fast_val = op_rem(op) ? '0 : dividend;
  end

  // Iteration datapath: the MSB of quo is the next dividend bit into rem.
  logic [N-1:0] rem_nx, quo_nx, final_val;
  logic         q_bit;

  div_step #(.N(N)) u_step (
    .rem      (rem),
    .divisor  (dvsr),
    .bit_in   (quo[N-1]),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  assign quo_nx = {quo[N-2:0], q_bit};

  // Sign fix applied to the values produced by the final iteration.
  always_comb begin
    final_val = '0;
    if (rem_sel) final_val = r_neg ? (~rem_nx + N'(1)) : rem_nx;
    else         final_val = q_neg ? (~quo_nx + N'(1)) : quo_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      rem_sel <= 1'b0;
      result  <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rem_sel <= op_rem(op);
            if (fast) begin
              result <= fast_val;
              state  <= DONE;
            end else begin
              rem   <= '0;
              quo   <= a_mag;
              dvsr  <= b_mag;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              cnt   <= CW'(N - 1);
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          // The iteration performed while cnt == 0 is the N-th and last one.
          if (cnt == '0) begin
            result <= final_val;
            state  <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule
